// File: rtl/nios2_mult_pipe.sv
// rtl/nios2_mult_pipe.sv - pipelined signed/unsigned half-word partial-product multiplier
module nios2_mult_pipe #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     result,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int H  = WIDTH / 2;
    localparam int NT = PIPE_STAGES - 1;

    logic               w_sign_a, w_sign_b;
    logic [WIDTH-1:0]   w_a_lo, w_a_hi, w_b_lo, w_b_hi;
    logic [WIDTH-1:0]   w_p1, w_p2, w_p3, w_p4;

    assign w_sign_a = op[1];
    assign w_sign_b = (op == 2'b11);

    // Halves widened to 2H bits; a modular 2H-bit product equals the exact
    // half-width product because every signed/unsigned mix fits in 2H bits.
    assign w_a_lo = {{H{1'b0}}, src1[H-1:0]};
    assign w_a_hi = {{H{w_sign_a & src1[WIDTH-1]}}, src1[WIDTH-1:H]};
    assign w_b_lo = {{H{1'b0}}, src2[H-1:0]};
    assign w_b_hi = {{H{w_sign_b & src2[WIDTH-1]}}, src2[WIDTH-1:H]};

    assign w_p1 = w_a_lo * w_b_lo;
    assign w_p2 = w_a_lo * w_b_hi;
    assign w_p3 = w_a_hi * w_b_lo;
    assign w_p4 = w_a_hi * w_b_hi;

    logic                 r_v1;
    logic [1:0]           r_op1;
    logic [WIDTH-1:0]     r_p1, r_p2, r_p3, r_p4;
    logic [NT-1:0]        r_v;
    logic [1:0]           r_op   [NT];
    logic [2*WIDTH-1:0]   r_prod [NT];

    logic                 w_sa1, w_sb1;
    logic [2*WIDTH-1:0]   w_sum;

    assign w_sa1 = r_op1[1];
    assign w_sb1 = (r_op1 == 2'b11);

    assign w_sum = {{WIDTH{1'b0}}, r_p1}
                 + ({{WIDTH{w_sb1 & r_p2[WIDTH-1]}}, r_p2} << H)
                 + ({{WIDTH{w_sa1 & r_p3[WIDTH-1]}}, r_p3} << H)
                 + ({{WIDTH{(w_sa1 | w_sb1) & r_p4[WIDTH-1]}}, r_p4} << WIDTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1  <= 1'b0;
            r_op1 <= 2'b00;
            r_p1  <= '0;
            r_p2  <= '0;
            r_p3  <= '0;
            r_p4  <= '0;
            r_v   <= '0;
            for (int i = 0; i < NT; i++) begin
                r_op[i]   <= 2'b00;
                r_prod[i] <= '0;
            end
        end else if (flush) begin
            r_v1 <= 1'b0;
            r_v  <= '0;
        end else if (en) begin
            r_v1      <= in_valid;
            r_op1     <= op;
            r_p1      <= w_p1;
            r_p2      <= w_p2;
            r_p3      <= w_p3;
            r_p4      <= w_p4;
            r_v[0]    <= r_v1;
            r_op[0]   <= r_op1;
            r_prod[0] <= w_sum;
            for (int i = 1; i < NT; i++) begin
                r_v[i]    <= r_v[i-1];
                r_op[i]   <= r_op[i-1];
                r_prod[i] <= r_prod[i-1];
            end
        end
    end

    assign out_valid = r_v[NT-1];
    assign product   = r_prod[NT-1];
    assign result    = (r_op[NT-1] == 2'b00) ? r_prod[NT-1][WIDTH-1:0]
                                             : r_prod[NT-1][2*WIDTH-1:WIDTH];
    assign busy      = r_v1 | (|r_v);

endmodule
